// File: rtl/branch_pkg.sv
// Shared definitions for the EX-stage branch resolver.
// Funct3 encodings, FSM states and the branch condition helper.
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    REDIRECT,
    FLUSH
  } br_state_e;

  function automatic logic br_taken(
    input logic [2:0] funct3,
    input logic       less,
    input logic       equal
  );
    logic t;
    t = 1'b0;
    case (funct3)
      F3_BEQ:  t = equal;
      F3_BNE:  t = !equal;
      F3_BLT:  t = less;
      F3_BGE:  t = !less;
      F3_BLTU: t = less;
      F3_BGEU: t = !less;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  function automatic logic f3_illegal(
    input logic [2:0] funct3
  );
    return (funct3 == 3'b010) ||
           (funct3 == 3'b011);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with async active-low clear.
// Sticks at all-ones once reached.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (i_inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign o_cnt = cnt_q;

endmodule

// File: rtl/branch_resolver.sv
// EX-stage branch/jump resolver: decides taken, computes the
// target, redirects fetch and flushes younger stages.
module branch_resolver
  import branch_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_ex_valid,
  output logic             o_ex_ready,
  input  logic             i_ex_is_br,
  input  logic             i_ex_is_jal,
  input  logic             i_ex_is_jalr,
  input  logic [2:0]       i_ex_funct3,
  input  logic [XLEN-1:0]  i_ex_pc,
  input  logic [XLEN-1:0]  i_ex_imm,
  input  logic [XLEN-1:0]  i_rs1_data,
  output logic             o_br_un,
  input  logic             i_br_less,
  input  logic             i_br_equal,
  output logic             o_redirect_valid,
  output logic [XLEN-1:0]  o_redirect_pc,
  input  logic             i_redirect_ready,
  output logic             o_flush,
  output logic             o_illegal,
  output logic             o_misalign,
  output logic [CNT_W-1:0] o_branch_cnt,
  output logic [CNT_W-1:0] o_taken_cnt
);

  localparam logic [3:0] FC_INIT =
    (FLUSH_CYCLES == 0) ? 4'd0 : 4'(FLUSH_CYCLES - 1);

  br_state_e       state_q;
  logic [3:0]      cnt_q;
  logic            rvalid_q;
  logic [XLEN-1:0] rpc_q;
  logic            flush_q;
  logic            illegal_q;
  logic            misalign_q;

  logic            accept;
  logic            taken;
  logic            illegal;
  logic            misalign;
  logic            redirect;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] jalr_sum;

  assign o_br_un    = i_ex_funct3[1];
  assign o_ex_ready = (state_q == IDLE);
  assign accept     = i_ex_valid & o_ex_ready;

  assign jalr_sum = i_rs1_data + i_ex_imm;

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    target  = i_ex_pc + i_ex_imm;
    if (i_ex_is_jalr) begin
      taken  = 1'b1;
      target = {jalr_sum[XLEN-1:1], 1'b0};
    end else if (i_ex_is_jal) begin
      taken = 1'b1;
    end else if (i_ex_is_br) begin
      taken   = br_taken(i_ex_funct3, i_br_less,
                         i_br_equal);
      illegal = f3_illegal(i_ex_funct3);
    end
  end

  // A taken target off a 4-byte boundary never redirects.
  assign misalign = taken & target[1];
  assign redirect = accept & taken & !target[1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rvalid_q   <= 1'b0;
      rpc_q      <= '0;
      flush_q    <= 1'b0;
      illegal_q  <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      illegal_q  <= accept & illegal;
      misalign_q <= accept & misalign;
      unique case (state_q)
        IDLE: begin
          if (redirect) begin
            state_q  <= REDIRECT;
            rpc_q    <= target;
            rvalid_q <= 1'b1;
            flush_q  <= 1'b1;
          end
        end
        REDIRECT: begin
          if (i_redirect_ready) begin
            rvalid_q <= 1'b0;
            if (FLUSH_CYCLES == 0) begin
              state_q <= IDLE;
              flush_q <= 1'b0;
            end else begin
              state_q <= FLUSH;
              cnt_q   <= FC_INIT;
            end
          end
        end
        FLUSH: begin
          if (cnt_q == 4'd0) begin
            state_q <= IDLE;
            flush_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_redirect_valid = rvalid_q;
  assign o_redirect_pc    = rpc_q;
  assign o_flush          = flush_q;
  assign o_illegal        = illegal_q;
  assign o_misalign       = misalign_q;

  sat_counter #(.W(CNT_W)) u_branch_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (accept),
    .o_cnt   (o_branch_cnt)
  );

  sat_counter #(.W(CNT_W)) u_taken_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (redirect),
    .o_cnt   (o_taken_cnt)
  );

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver (4-bit counters so
// saturation is reachable).
module tb_branch_resolver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic        is_br = 1'b0;
  logic        is_jal = 1'b0;
  logic        is_jalr = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] pc = '0;
  logic [31:0] imm = '0;
  logic [31:0] rs1 = '0;
  logic        br_un;
  logic        less = 1'b0;
  logic        equal = 1'b0;
  logic        rvalid;
  logic [31:0] rpc;
  logic        rready = 1'b1;
  logic        flush;
  logic        illegal;
  logic        misalign;
  logic [3:0]  bcnt;
  logic [3:0]  tcnt;

  int checks = 0;
  int errors = 0;
  int n_fl;
  int n_nr;

  always #5 clk = ~clk;

  branch_resolver #(
    .XLEN(32), .FLUSH_CYCLES(2), .CNT_W(4)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_ex_valid       (ex_valid),
    .o_ex_ready       (ex_ready),
    .i_ex_is_br       (is_br),
    .i_ex_is_jal      (is_jal),
    .i_ex_is_jalr     (is_jalr),
    .i_ex_funct3      (funct3),
    .i_ex_pc          (pc),
    .i_ex_imm         (imm),
    .i_rs1_data       (rs1),
    .o_br_un          (br_un),
    .i_br_less        (less),
    .i_br_equal       (equal),
    .o_redirect_valid (rvalid),
    .o_redirect_pc    (rpc),
    .i_redirect_ready (rready),
    .o_flush          (flush),
    .o_illegal        (illegal),
    .o_misalign       (misalign),
    .o_branch_cnt     (bcnt),
    .o_taken_cnt      (tcnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    ex_valid = 1'b0;
    is_br = 1'b0;
    is_jal = 1'b0;
    is_jalr = 1'b0;
  endtask

  task automatic br(input logic [2:0] f3,
                    input logic [31:0] p,
                    input logic [31:0] i,
                    input logic l, input logic e);
    idle_in();
    ex_valid = 1'b1;
    is_br = 1'b1;
    funct3 = f3;
    pc = p;
    imm = i;
    less = l;
    equal = e;
  endtask

  task automatic jmp(input logic jr,
                     input logic [31:0] p,
                     input logic [31:0] i,
                     input logic [31:0] r);
    idle_in();
    ex_valid = 1'b1;
    is_jal = !jr;
    is_jalr = jr;
    pc = p;
    imm = i;
    rs1 = r;
  endtask

  // Counts flush-high and ready-low cycles until idle.
  task automatic drain();
    n_fl = 0;
    n_nr = 0;
    for (int k = 0; k < 20; k++) begin
      if (!flush && ex_ready) break;
      if (flush) n_fl++;
      if (!ex_ready) n_nr++;
      step();
    end
    chk("drain_idle", {31'd0, ex_ready}, 32'd1);
  endtask

  initial begin
    #12;
    chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_rpc", rpc, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_ready", {31'd0, ex_ready}, 32'd1);
    chk("rst_bcnt", {28'd0, bcnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    br(3'b000, 32'h100, 32'h20, 1'b0, 1'b1);
    chk("beq_un", {31'd0, br_un}, 32'd0);
    step();
    idle_in();
    chk("beq_rvalid", {31'd0, rvalid}, 32'd1);
    chk("beq_rpc", rpc, 32'h120);
    chk("beq_tcnt", {28'd0, tcnt}, 32'd1);
    drain();
    chk("beq_flush_n", n_fl, 32'd3);
    chk("beq_nready_n", n_nr, 32'd3);

    br(3'b110, 32'h200, 32'h40, 1'b0, 1'b0);
    chk("bltu_un", {31'd0, br_un}, 32'd1);
    step();
    chk("bltu_rvalid", {31'd0, rvalid}, 32'd0);
    chk("bltu_ready", {31'd0, ex_ready}, 32'd1);
    chk("bltu_bcnt", {28'd0, bcnt}, 32'd2);
    chk("bltu_tcnt", {28'd0, tcnt}, 32'd1);
    br(3'b001, 32'h200, 32'h40, 1'b0, 1'b0);
    step();
    idle_in();
    chk("bne_rvalid", {31'd0, rvalid}, 32'd1);
    chk("bne_rpc", rpc, 32'h240);
    chk("bne_tcnt", {28'd0, tcnt}, 32'd2);
    drain();

    jmp(1'b1, 32'h0, 32'h1, 32'h1004);
    step();
    idle_in();
    chk("jalr_rpc", rpc, 32'h1004);
    chk("jalr_rvalid", {31'd0, rvalid}, 32'd1);
    drain();
    jmp(1'b1, 32'h0, 32'h4, 32'h1003);
    step();
    idle_in();
    chk("jalr6_mis", {31'd0, misalign}, 32'd1);
    chk("jalr6_rvalid", {31'd0, rvalid}, 32'd0);
    jmp(1'b1, 32'h0, 32'h1, 32'h1001);
    step();
    idle_in();
    chk("jalr2_mis", {31'd0, misalign}, 32'd1);
    chk("jalr2_rvalid", {31'd0, rvalid}, 32'd0);
    chk("mis_bcnt", {28'd0, bcnt}, 32'd6);
    chk("mis_tcnt", {28'd0, tcnt}, 32'd3);
    step();
    chk("mis_pulse_end", {31'd0, misalign}, 32'd0);

    rready = 1'b0;
    jmp(1'b0, 32'h300, 32'h10, 32'h0);
    step();
    for (int i = 0; i < 4; i++) begin
      br(3'b000, 32'h400, 32'h8, 1'b0, 1'b1);
      chk("hold_rvalid", {31'd0, rvalid}, 32'd1);
      chk("hold_rpc", rpc, 32'h310);
      step();
    end
    idle_in();
    rready = 1'b1;
    step();
    chk("hs_rvalid", {31'd0, rvalid}, 32'd0);
    drain();
    chk("hs_flush_n", n_fl, 32'd2);
    chk("hold_bcnt", {28'd0, bcnt}, 32'd7);
    chk("hold_tcnt", {28'd0, tcnt}, 32'd4);

    br(3'b011, 32'h500, 32'h8, 1'b1, 1'b1);
    step();
    idle_in();
    chk("ill_pulse", {31'd0, illegal}, 32'd1);
    chk("ill_rvalid", {31'd0, rvalid}, 32'd0);
    step();
    chk("ill_end", {31'd0, illegal}, 32'd0);

    br(3'b000, 32'h600, 32'h8, 1'b0, 1'b1);
    step();
    idle_in();
    step();
    chk("mid_flush", {31'd0, flush}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_flush", {31'd0, flush}, 32'd0);
    chk("arst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("arst_rpc", rpc, 32'd0);
    chk("arst_ready", {31'd0, ex_ready}, 32'd1);
    chk("arst_bcnt", {28'd0, bcnt}, 32'd0);
    chk("arst_tcnt", {28'd0, tcnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 17; i++) begin
      br(3'b000, 32'h700, 32'h10, 1'b0, 1'b1);
      step();
      idle_in();
      drain();
      if (i == 13)
        chk("sat_14", {28'd0, tcnt}, 32'hE);
    end
    chk("sat_tcnt", {28'd0, tcnt}, 32'hF);
    chk("sat_bcnt", {28'd0, bcnt}, 32'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- Consumes the flags from the branch comparator and drives its unsigned-select input.
- Resolves BEQ/BNE/BLT/BGE/BLTU/BGEU/JAL/JALR in the EX stage and computes the target.
- Issues a PC redirect to fetch over a valid/ready handshake, then flushes younger pipeline stages for a fixed number of cycles.
- Predicts not-taken: only taken control transfers redirect.

Parameters:
- XLEN, 32, data/address width.
- FLUSH_CYCLES, 2, cycles o_flush stays high after the redirect handshake (0..15).
- CNT_W, 32, width of the performance counters.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_ex_valid  in  1  EX holds a control-transfer instruction.
- o_ex_ready  out  1  block can accept an EX instruction.
- i_ex_is_br  in  1  conditional branch.
- i_ex_is_jal  in  1  JAL.
- i_ex_is_jalr  in  1  JALR.
- i_ex_funct3  in  3  branch funct3.
- i_ex_pc  in  XLEN  instruction PC.
- i_ex_imm  in  XLEN  sign-extended immediate.
- i_rs1_data  in  XLEN  rs1 operand, used for the JALR base.
- o_br_un  out  1  unsigned compare select to the comparator.
- i_br_less  in  1  comparator: rs1 < rs2.
- i_br_equal  in  1  comparator: rs1 == rs2.
- o_redirect_valid  out  1  redirect request to fetch.
- o_redirect_pc  out  XLEN  redirect target.
- i_redirect_ready  in  1  fetch accepts the redirect.
- o_flush  out  1  kill IF/ID contents.
- o_illegal  out  1  one-cycle pulse: branch with funct3 010/011.
- o_misalign  out  1  one-cycle pulse: taken target with bit1 set.
- o_branch_cnt  out  CNT_W  resolved control transfers.
- o_taken_cnt  out  CNT_W  taken control transfers.

Behaviour:
- Reset (async, any state): state IDLE. Outputs: o_redirect_valid=0, o_redirect_pc=0, o_flush=0, o_illegal=0, o_misalign=0, both counters=0, o_ex_ready=1.
- o_br_un is combinational: i_ex_funct3[1]. It is valid whenever i_ex_is_br=1, regardless of state.
- Accept = i_ex_valid & o_ex_ready. Only one of is_br/is_jal/is_jalr is expected; priority is jalr > jal > br.
- Taken decision (combinational at accept):
  - BEQ(000): equal. BNE(001): !equal.
  - BLT(100)/BLTU(110): less. BGE(101)/BGEU(111): !less.
  - JAL/JALR: always taken.
  - funct3 010/011: not taken, and o_illegal pulses the next cycle.
- Target: branch and JAL use pc+imm; JALR uses (rs1+imm) & ~1. Arithmetic is modulo 2^XLEN (wrap-around, no overflow flag).
- Taken with target[1]=1: no redirect, and o_misalign pulses the next cycle. It counts as a branch but not as taken.
- FSM, states IDLE / REDIRECT / FLUSH:
  - IDLE: o_ex_ready=1. A taken accept moves to REDIRECT next cycle, registering o_redirect_pc and setting o_redirect_valid=1 and o_flush=1. A not-taken accept stays in IDLE (zero-bubble).
  - REDIRECT: o_ex_ready=0. o_redirect_valid and o_redirect_pc are held stable until i_redirect_ready=1. On the handshake cycle, o_redirect_valid drops next cycle. The FSM then goes to FLUSH with cnt=FLUSH_CYCLES-1, or to IDLE if FLUSH_CYCLES=0. o_flush stays high throughout REDIRECT.
  - FLUSH: o_flush=1, o_ex_ready=0. cnt decrements each cycle; at cnt=0 the FSM goes to IDLE.
  - Result: o_flush is high for the REDIRECT cycles plus exactly FLUSH_CYCLES cycles.
- i_redirect_ready high in the same cycle that REDIRECT is entered completes the handshake in that first cycle.
- Counters:
  - o_branch_cnt increments on every accept; o_taken_cnt on every accept that actually redirects.
  - Both are registered (visible next cycle) and saturate at all-ones.
- i_ex_valid while o_ex_ready=0 is ignored; no counting, no pulses.
- Flags and operands are sampled only on the accept cycle.

Decomposition:
- Package branch_pkg holds:
  - funct3 localparams F3_BEQ..F3_BGEU;
  - typedef enum logic [1:0] br_state_e {IDLE, REDIRECT, FLUSH};
  - function br_taken(funct3, less, equal).
- One natural sub-module, sat_counter (param W, inc, async active-low clear), instantiated twice for the counters.
- Decision logic, target adder and FSM stay in branch_resolver.

Test Plan:
- BEQ, pc=0x100, imm=0x20, equal=1, ready held 1 → o_redirect_pc=0x120 one cycle after accept; o_flush high 1+2=3 cycles; o_ex_ready low 3 cycles; taken_cnt=1.
- BLTU (110), less=0 → o_br_un=1; no redirect; o_ex_ready stays 1; branch_cnt=1, taken_cnt=0. Back-to-back BNE with equal=0 on the next cycle is accepted and redirects.
- JALR, rs1=0x1003, imm=0x4 → target 0x1006 (bit0 cleared). With rs1=0x1001, imm=0x1 → target 0x1002: o_misalign pulse, no redirect.
- Taken JAL with i_redirect_ready low for 4 cycles → o_redirect_valid and o_redirect_pc stable all 4 cycles; i_ex_valid pulses in that window are ignored; flush ends FLUSH_CYCLES cycles after the handshake.
- funct3=011 branch → o_illegal one-cycle pulse; no redirect. i_rst_n asserted mid-FLUSH → all outputs 0 immediately, o_ex_ready=1, counters cleared.
- CNT_W=4: 17 taken branches → o_taken_cnt saturates at 0xF.
